// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle control unit for the 16-bit CPU.
// Drives the phase code the datapath keys off, runs the instruction fetch
// handshake, stretches execute for multiply, and supports free-run,
// single-step and halt modes.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | stopped; waiting for run level or a step pulse
//   FETCH | imem_req held, waiting for imem_ack (timeout guarded)
//   EXEC  | one PH2 cycle; ALU result latched on the edge leaving it
//   MWAIT | extra PH2 cycles for multi-cycle multiply
//   WB    | one PH3 cycle; register file / PC write strobes
//   HALT  | HALT instruction or fault; left only through RST
module cpu_sequencer #(
    parameter int MUL_CYCLES = 2,
    parameter int FETCH_TMO  = 15
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        run,
    input  logic        step,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic        dec_mlt,
    input  logic        dec_store,
    input  logic        dec_branch,
    input  logic        dec_halt,
    input  logic        dec_illegal,
    output logic [3:0]  ph,
    output logic        ir_we,
    output logic        pc_inc,
    output logic        pc_we,
    output logic        rf_we,
    output logic        busy,
    output logic        halted,
    output logic [1:0]  fault,
    output logic [15:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_MWAIT,
        S_WB,
        S_HALT
    } state_t;

    localparam logic [3:0] PH_NONE  = 4'b0000;
    localparam logic [3:0] PH_FETCH = 4'b0001;
    localparam logic [3:0] PH_EXEC  = 4'b0010;
    localparam logic [3:0] PH_WB    = 4'b0100;

    localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
    localparam logic [1:0] FAULT_TMO     = 2'b10;

    // Timer reload values: the timer counts down and the terminal count (0)
    // marks the last cycle, so a load of N-1 gives exactly N cycles.
    localparam logic [7:0] TMO_LOAD = 8'(FETCH_TMO - 1);
    localparam logic [7:0] MUL_LOAD = (MUL_CYCLES > 0) ? 8'(MUL_CYCLES - 1) : 8'd0;

    state_t      state;
    logic [7:0]  tmr;
    logic        step_mode;
    logic [15:0] ret_cnt;

    // The ir is captured on the edge that ends the ack cycle, so these two
    // strobes follow imem_ack directly instead of waiting a register stage.
    // RST masks them so a reset edge never loads a stray instruction.
    assign ir_we   = (state == S_FETCH) && imem_ack && !RST;
    assign pc_inc  = (state == S_FETCH) && imem_ack && !RST;
    assign retired = ret_cnt;

    // Sequencer FSM: state, fetch/multiply timer, retire counter and all
    // registered outputs, each output decoded from the state being entered.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= S_IDLE;
            tmr       <= 8'd0;
            step_mode <= 1'b0;
            ret_cnt   <= 16'd0;
            ph        <= PH_NONE;
            imem_req  <= 1'b0;
            pc_we     <= 1'b0;
            rf_we     <= 1'b0;
            busy      <= 1'b0;
            halted    <= 1'b0;
            fault     <= 2'b00;
        end else begin
            pc_we <= 1'b0;
            rf_we <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (run || step) begin
                        state     <= S_FETCH;
                        step_mode <= !run;
                        tmr       <= TMO_LOAD;
                        ph        <= PH_FETCH;
                        imem_req  <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        state    <= S_EXEC;
                        ph       <= PH_EXEC;
                        imem_req <= 1'b0;
                    end else if (tmr == 8'd0) begin
                        state    <= S_HALT;
                        ph       <= PH_NONE;
                        imem_req <= 1'b0;
                        busy     <= 1'b0;
                        halted   <= 1'b1;
                        fault    <= FAULT_TMO;
                    end else begin
                        tmr <= tmr - 8'd1;
                    end
                end
                S_EXEC: begin
                    if (dec_illegal) begin
                        state  <= S_HALT;
                        ph     <= PH_NONE;
                        busy   <= 1'b0;
                        halted <= 1'b1;
                        fault  <= FAULT_ILLEGAL;
                    end else if (dec_halt) begin
                        state   <= S_HALT;
                        ph      <= PH_NONE;
                        busy    <= 1'b0;
                        halted  <= 1'b1;
                        ret_cnt <= ret_cnt + 16'd1;
                    end else if (dec_mlt && (MUL_CYCLES > 0)) begin
                        state <= S_MWAIT;
                        tmr   <= MUL_LOAD;
                    end else begin
                        state   <= S_WB;
                        ph      <= PH_WB;
                        rf_we   <= dec_store;
                        pc_we   <= dec_branch;
                        ret_cnt <= ret_cnt + 16'd1;
                    end
                end
                S_MWAIT: begin
                    if (tmr == 8'd0) begin
                        state   <= S_WB;
                        ph      <= PH_WB;
                        rf_we   <= dec_store;
                        pc_we   <= dec_branch;
                        ret_cnt <= ret_cnt + 16'd1;
                    end else begin
                        tmr <= tmr - 8'd1;
                    end
                end
                S_WB: begin
                    // A stepped instruction always stops, even if run rose meanwhile.
                    if (run && !step_mode) begin
                        state    <= S_FETCH;
                        tmr      <= TMO_LOAD;
                        ph       <= PH_FETCH;
                        imem_req <= 1'b1;
                        busy     <= 1'b1;
                    end else begin
                        state <= S_IDLE;
                        ph    <= PH_NONE;
                        busy  <= 1'b0;
                    end
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state    <= S_IDLE;
                    ph       <= PH_NONE;
                    imem_req <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed scenarios for cpu_sequencer with a per-cycle
// expected-output scoreboard.
module tb_cpu_sequencer;

    logic        CLK;
    logic        RST;
    logic        run;
    logic        step;
    logic        imem_req;
    logic        imem_ack;
    logic        dec_mlt;
    logic        dec_store;
    logic        dec_branch;
    logic        dec_halt;
    logic        dec_illegal;
    logic [3:0]  ph;
    logic        ir_we;
    logic        pc_inc;
    logic        pc_we;
    logic        rf_we;
    logic        busy;
    logic        halted;
    logic [1:0]  fault;
    logic [15:0] retired;

    int errors = 0;
    int checks = 0;

    logic [12:0] exp_q[$];
    logic [12:0] obs;

    // {ph, imem_req, ir_we, pc_inc, pc_we, rf_we, busy, halted, fault}
    localparam logic [12:0] E_IDLE    = 13'b0000_0_0_0_0_0_0_0_00;
    localparam logic [12:0] E_FETCH   = 13'b0001_1_0_0_0_0_1_0_00;
    localparam logic [12:0] E_FACK    = 13'b0001_1_1_1_0_0_1_0_00;
    localparam logic [12:0] E_EXEC    = 13'b0010_0_0_0_0_0_1_0_00;
    localparam logic [12:0] E_WB_RF   = 13'b0100_0_0_0_0_1_1_0_00;
    localparam logic [12:0] E_WB_PC   = 13'b0100_0_0_0_1_0_1_0_00;
    localparam logic [12:0] E_WB_NONE = 13'b0100_0_0_0_0_0_1_0_00;
    localparam logic [12:0] E_HALT00  = 13'b0000_0_0_0_0_0_0_1_00;
    localparam logic [12:0] E_HALT01  = 13'b0000_0_0_0_0_0_0_1_01;
    localparam logic [12:0] E_HALT10  = 13'b0000_0_0_0_0_0_0_1_10;

    assign obs = {ph, imem_req, ir_we, pc_inc, pc_we, rf_we, busy, halted, fault};

    cpu_sequencer #(
        .MUL_CYCLES(2),
        .FETCH_TMO (15)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .run        (run),
        .step       (step),
        .imem_req   (imem_req),
        .imem_ack   (imem_ack),
        .dec_mlt    (dec_mlt),
        .dec_store  (dec_store),
        .dec_branch (dec_branch),
        .dec_halt   (dec_halt),
        .dec_illegal(dec_illegal),
        .ph         (ph),
        .ir_we      (ir_we),
        .pc_inc     (pc_inc),
        .pc_we      (pc_we),
        .rf_we      (rf_we),
        .busy       (busy),
        .halted     (halted),
        .fault      (fault),
        .retired    (retired)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Inputs are already set for this cycle; queue the expected outputs,
    // then pop and compare mid-cycle and advance past the next edge.
    task automatic cyc(input logic [12:0] e, input string tag);
        logic [12:0] want;
        exp_q.push_back(e);
        @(negedge CLK);
        want = exp_q.pop_front();
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, want);
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_ret(input logic [15:0] e, input string tag);
        checks++;
        assert (retired === e) else begin
            errors++;
            $error("FAIL %s retired observed=%h expected=%h", tag, retired, e);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RST = 1'b1; run = 1'b0; step = 1'b0; imem_ack = 1'b0;
        dec_mlt = 1'b0; dec_store = 1'b0; dec_branch = 1'b0;
        dec_halt = 1'b0; dec_illegal = 1'b0;
        @(posedge CLK);
        #1;
        cyc(E_IDLE, "reset_outputs");
        chk_ret(16'h0000, "reset_retired");

        // reset held mid-fetch with ack present
        RST = 1'b0; run = 1'b1;
        cyc(E_IDLE, "t1_idle");
        cyc(E_FETCH, "t1_fetch");
        RST = 1'b1; imem_ack = 1'b1;
        cyc(E_FETCH, "t1_rst_in_fetch");
        RST = 1'b0; imem_ack = 1'b0; run = 1'b0;
        cyc(E_IDLE, "t1_after_rst");
        chk_ret(16'h0000, "t1_retired");

        // ADD, ack on second fetch cycle, run drops during WB
        run = 1'b1;
        cyc(E_IDLE, "t2_idle");
        cyc(E_FETCH, "t2_fetch1");
        imem_ack = 1'b1;
        cyc(E_FACK, "t2_fetch2_ack");
        imem_ack = 1'b0; dec_store = 1'b1;
        cyc(E_EXEC, "t2_exec");
        run = 1'b0;
        cyc(E_WB_RF, "t2_wb");
        dec_store = 1'b0;
        chk_ret(16'h0001, "t2_retired");
        cyc(E_IDLE, "t2_stop");

        // MLT: three PH2 cycles then WB
        run = 1'b1;
        cyc(E_IDLE, "t3_idle");
        imem_ack = 1'b1;
        cyc(E_FACK, "t3_fetch_ack");
        imem_ack = 1'b0; dec_mlt = 1'b1; dec_store = 1'b1;
        cyc(E_EXEC, "t3_exec");
        cyc(E_EXEC, "t3_mwait1");
        cyc(E_EXEC, "t3_mwait2");
        run = 1'b0;
        cyc(E_WB_RF, "t3_wb");
        dec_mlt = 1'b0; dec_store = 1'b0;
        cyc(E_IDLE, "t3_stop");
        chk_ret(16'h0002, "t3_retired");

        // single step BZ; second step while busy and late run are ignored
        step = 1'b1;
        cyc(E_IDLE, "t4_idle_step");
        step = 1'b0; imem_ack = 1'b1;
        cyc(E_FACK, "t4_fetch_ack");
        imem_ack = 1'b0; dec_branch = 1'b1; step = 1'b1;
        cyc(E_EXEC, "t4_exec");
        step = 1'b0; run = 1'b1;
        cyc(E_WB_PC, "t4_wb");
        run = 1'b0; dec_branch = 1'b0;
        cyc(E_IDLE, "t4_back_idle");
        cyc(E_IDLE, "t4_step_not_queued");
        chk_ret(16'h0003, "t4_retired");

        // HALT instruction beats MLT and retires
        run = 1'b1;
        cyc(E_IDLE, "h_idle");
        imem_ack = 1'b1;
        cyc(E_FACK, "h_fetch_ack");
        imem_ack = 1'b0; dec_halt = 1'b1; dec_mlt = 1'b1;
        cyc(E_EXEC, "h_exec");
        dec_halt = 1'b0; dec_mlt = 1'b0; run = 1'b0;
        cyc(E_HALT00, "h_halted");
        step = 1'b1;
        cyc(E_HALT00, "h_ignores_step");
        step = 1'b0;
        chk_ret(16'h0004, "h_retired");
        RST = 1'b1;
        cyc(E_HALT00, "h_rst_cycle");
        RST = 1'b0;
        cyc(E_IDLE, "h_exit_rst");
        chk_ret(16'h0000, "h_retired_cleared");

        // illegal beats MLT: fault 01, no write, no retire
        run = 1'b1;
        cyc(E_IDLE, "ill_idle");
        imem_ack = 1'b1;
        cyc(E_FACK, "ill_fetch_ack");
        imem_ack = 1'b0; dec_illegal = 1'b1; dec_mlt = 1'b1; dec_store = 1'b1;
        cyc(E_EXEC, "ill_exec");
        dec_illegal = 1'b0; dec_mlt = 1'b0; dec_store = 1'b0;
        cyc(E_HALT01, "ill_halt");
        cyc(E_HALT01, "ill_sticky");
        run = 1'b0;
        chk_ret(16'h0000, "ill_no_retire");
        RST = 1'b1;
        cyc(E_HALT01, "ill_rst_cycle");
        RST = 1'b0;
        cyc(E_IDLE, "ill_exit_rst");

        // ack in the final timeout cycle wins; NOP still retires
        run = 1'b1;
        cyc(E_IDLE, "tb_idle");
        for (int i = 0; i < 14; i++) cyc(E_FETCH, "tb_wait");
        imem_ack = 1'b1;
        cyc(E_FACK, "tb_ack_wins");
        imem_ack = 1'b0;
        cyc(E_EXEC, "nop_exec");
        run = 1'b0;
        cyc(E_WB_NONE, "nop_wb");
        cyc(E_IDLE, "nop_stop");
        chk_ret(16'h0001, "nop_retired");

        // fetch timeout after 15 cycles, held until reset
        run = 1'b1;
        cyc(E_IDLE, "tmo_idle");
        for (int i = 0; i < 15; i++) cyc(E_FETCH, "tmo_wait");
        cyc(E_HALT10, "tmo_halt");
        imem_ack = 1'b1;
        for (int i = 0; i < 3; i++) cyc(E_HALT10, "tmo_held");
        imem_ack = 1'b0; run = 1'b0;
        chk_ret(16'h0001, "tmo_retired");
        RST = 1'b1;
        cyc(E_HALT10, "tmo_rst_cycle");
        RST = 1'b0;
        cyc(E_IDLE, "tmo_exit_rst");
        chk_ret(16'h0000, "tmo_retired_cleared");

        // retired wraps FFFF -> 0000
        force dut.ret_cnt = 16'hFFFF;
        @(negedge CLK);
        release dut.ret_cnt;
        @(posedge CLK);
        #1;
        chk_ret(16'hFFFF, "wrap_preset");
        run = 1'b1;
        cyc(E_IDLE, "wrap_idle");
        imem_ack = 1'b1;
        cyc(E_FACK, "wrap_fetch_ack");
        imem_ack = 1'b0; dec_store = 1'b1;
        cyc(E_EXEC, "wrap_exec");
        run = 1'b0;
        cyc(E_WB_RF, "wrap_wb");
        dec_store = 1'b0;
        cyc(E_IDLE, "wrap_stop");
        chk_ret(16'h0000, "wrap_retired");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
